// File: rtl/packet_gen_traffic.sv
// Ring-network traffic generator: periodic injection requests, a saturating pending
// counter, a single-entry valid/ready output register and per-node send/drop statistics.
module packet_gen_traffic #(
    parameter int          NUM_NODES            = 8,
    parameter int          ROUTER_ID            = 0,
    parameter int          ID_WIDTH             = 16,
    parameter int          TRAFFIC_PATTERN      = 0,
    parameter int          HOTSPOT_ID           = 0,
    parameter int          INJECT_CYCLE         = 2,
    parameter int          NUM_PACKETS_PER_NODE = 20,
    parameter int          MAX_PENDING          = 4,
    parameter logic [15:0] LFSR_SEED            = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [15:0]             clk_counter,
    input  logic [15:0]             inject_clk_ref,
    input  logic                    gen_en,
    input  logic                    pkt_ready,
    output logic                    pkt_valid,
    output logic [16+2*ID_WIDTH:0]  packet,
    output logic [1:0]              route_dir,
    output logic [63:0]             total_packet_sent,
    output logic [63:0]             total_packet_dropped,
    output logic                    gen_done
);

    localparam int                PACKET_SIZE  = 1 + 16 + 2 * ID_WIDTH;
    localparam int                LOG_N        = $clog2(NUM_NODES);
    localparam int                PEND_W       = $clog2(MAX_PENDING + 1);
    localparam logic [15:0]       SEED_MIX     = LFSR_SEED ^ 16'(ROUTER_ID);
    localparam logic [15:0]       SEED         = (SEED_MIX == 16'h0) ? 16'hACE1 : SEED_MIX;
    localparam logic [ID_WIDTH-1:0] SRC        = ID_WIDTH'(ROUTER_ID);
    localparam logic [31:0]       QUOTA        = 32'(NUM_PACKETS_PER_NODE);
    localparam logic [PEND_W-1:0] PEND_MAX     = PEND_W'(MAX_PENDING);
    localparam logic [15:0]       INJECT_PHASE = 16'(INJECT_CYCLE - 1);

    typedef enum logic [1:0] {IDLE, VALID, DONE} state_t;

    state_t                 state_q, state_d;
    logic [PEND_W-1:0]      pending_q, pending_d;
    logic [31:0]            loaded_q, loaded_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic [PACKET_SIZE-1:0] packet_q, packet_d;
    logic [1:0]             route_q, route_d;
    logic [63:0]            sent_q, sent_d;
    logic [63:0]            dropped_q, dropped_d;
    logic                   done_q, done_d;

    logic                   quota_ok;
    logic                   req;
    logic                   load;
    logic                   handshake;
    logic                   final_hs;
    logic [ID_WIDTH-1:0]    dst;
    logic [1:0]             route_nxt;

    // Loaded-plus-pending bounds the quota so drops never consume quota slots.
    assign quota_ok  = (QUOTA == 32'd0) || ((loaded_q + 32'(pending_q)) < QUOTA);
    assign req       = gen_en && (inject_clk_ref == INJECT_PHASE) && !done_q && quota_ok;
    assign handshake = (state_q == VALID) && pkt_ready;
    assign load      = (pending_q != '0) && (state_q != DONE) && ((state_q != VALID) || pkt_ready);
    assign final_hs  = handshake && (QUOTA != 32'd0) && ((sent_q + 64'd1) == 64'(QUOTA));

    always_comb begin : dst_calc
        int dst_int;
        int diff;
        dst_int = 0;
        case (TRAFFIC_PATTERN)
            0: dst_int = NUM_NODES - 1 - ROUTER_ID;
            1: dst_int = (ROUTER_ID + 1) % NUM_NODES;
            2: begin
                dst_int = int'(lfsr_q[LOG_N-1:0]);
                if (dst_int == ROUTER_ID) dst_int = (ROUTER_ID + 1) % NUM_NODES;
            end
            3: dst_int = (ROUTER_ID == HOTSPOT_ID) ? (ROUTER_ID + 1) % NUM_NODES : HOTSPOT_ID;
            4: dst_int = (ROUTER_ID + NUM_NODES / 2) % NUM_NODES;
            default: dst_int = 0;
        endcase
        diff = (dst_int + NUM_NODES - ROUTER_ID) % NUM_NODES;
        if (diff == 0) begin
            route_nxt = 2'b00;
        end else if (diff <= NUM_NODES / 2) begin
            route_nxt = 2'b01;
        end else begin
            route_nxt = 2'b10;
        end
        dst = ID_WIDTH'(dst_int);
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        loaded_d  = loaded_q;
        lfsr_d    = lfsr_q;
        packet_d  = packet_q;
        route_d   = route_q;
        sent_d    = sent_q;
        dropped_d = dropped_q;
        done_d    = done_q;

        if (handshake) sent_d = sent_q + 64'd1;
        if ((QUOTA != 32'd0) && (sent_q == 64'(QUOTA))) done_d = 1'b1;

        if (load) begin
            packet_d = {1'b1, clk_counter, SRC, dst};
            route_d  = route_nxt;
            loaded_d = loaded_q + 32'd1;
            // Fibonacci taps 16,14,13,11 in right-shift form.
            lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end

        if (req && !load) begin
            if (pending_q == PEND_MAX) begin
                dropped_d = dropped_q + 64'd1;
            end else begin
                pending_d = pending_q + 1'b1;
            end
        end else if (!req && load) begin
            pending_d = pending_q - 1'b1;
        end

        case (state_q)
            IDLE:    if (load) state_d = VALID;
            VALID: begin
                if (final_hs) begin
                    state_d = DONE;
                end else if (handshake && !load) begin
                    state_d = IDLE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            loaded_q  <= '0;
            lfsr_q    <= SEED;
            packet_q  <= '0;
            route_q   <= 2'b00;
            sent_q    <= '0;
            dropped_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            loaded_q  <= loaded_d;
            lfsr_q    <= lfsr_d;
            packet_q  <= packet_d;
            route_q   <= route_d;
            sent_q    <= sent_d;
            dropped_q <= dropped_d;
            done_q    <= done_d;
        end
    end

    assign pkt_valid            = (state_q == VALID);
    assign packet               = packet_q;
    assign route_dir            = route_q;
    assign total_packet_sent    = sent_q;
    assign total_packet_dropped = dropped_q;
    assign gen_done             = done_q;

endmodule

// File: tb/tb_packet_gen_traffic.sv
// Bench for packet_gen_traffic: several generator instances with different patterns share
// one stimulus stream and are compared against a transaction-level model.
module tb_packet_gen_traffic;

    localparam int NI   = 6;
    localparam int N    = 8;
    localparam int INJ  = 2;
    localparam int MAXP = 4;
    localparam int P_ID  [NI] = '{2, 0, 1, 6, 7, 1};
    localparam int P_PAT [NI] = '{0, 2, 4, 1, 0, 3};
    localparam int P_HOT [NI] = '{0, 0, 0, 0, 0, 6};
    localparam int P_Q   [NI] = '{20, 0, 3, 0, 0, 0};
    // Expected destination / direction per instance (-1: random pattern, checked separately).
    localparam int EXP_DST [NI] = '{5, -1, 5, 7, 0, 6};
    localparam int EXP_RD  [NI] = '{1, -1, 1, 1, 1, 2};

    logic        clk;
    logic        rst_n;
    logic [15:0] clk_counter;
    logic [15:0] inject_clk_ref;
    logic        gen_en;
    logic        pkt_ready;

    logic        pv [NI];
    logic [48:0] pk [NI];
    logic [1:0]  rd [NI];
    logic [63:0] ts [NI];
    logic [63:0] td [NI];
    logic        gd [NI];

    int checks = 0;
    int errors = 0;

    // Reference model state, one slot per instance.
    int          m_pend   [NI];
    int          m_loaded [NI];
    bit          m_valid  [NI];
    logic [48:0] m_pkt    [NI];
    logic [1:0]  m_rd     [NI];
    longint      m_sent   [NI];
    longint      m_drop   [NI];
    bit          m_done   [NI];
    logic [15:0] m_lfsr   [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        packet_gen_traffic #(
            .NUM_NODES(N), .ROUTER_ID(P_ID[gi]), .ID_WIDTH(16), .TRAFFIC_PATTERN(P_PAT[gi]),
            .HOTSPOT_ID(P_HOT[gi]), .INJECT_CYCLE(INJ), .NUM_PACKETS_PER_NODE(P_Q[gi]),
            .MAX_PENDING(MAXP), .LFSR_SEED(16'hACE1)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .clk_counter(clk_counter), .inject_clk_ref(inject_clk_ref),
            .gen_en(gen_en), .pkt_ready(pkt_ready), .pkt_valid(pv[gi]), .packet(pk[gi]),
            .route_dir(rd[gi]), .total_packet_sent(ts[gi]), .total_packet_dropped(td[gi]),
            .gen_done(gd[gi])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] lfsr_next(logic [15:0] x);
        logic fb;
        fb = x[0] ^ x[2] ^ x[3] ^ x[5];
        return {fb, x[15:1]};
    endfunction

    function automatic int exp_dst(int k, logic [15:0] lf);
        int src;
        int d;
        src = P_ID[k];
        case (P_PAT[k])
            0: d = N - 1 - src;
            1: d = (src + 1) % N;
            2: begin
                d = int'(lf) % N;
                if (d == src) d = (src + 1) % N;
            end
            3: d = (src == P_HOT[k]) ? (src + 1) % N : P_HOT[k];
            4: d = (src + N / 2) % N;
            default: d = 0;
        endcase
        return d;
    endfunction

    function automatic logic [1:0] exp_route(int src, int dst);
        int d;
        d = (dst - src + N) % N;
        if (d == 0) return 2'b00;
        if (d <= N / 2) return 2'b01;
        return 2'b10;
    endfunction

    task automatic model_reset();
        logic [15:0] s;
        for (int k = 0; k < NI; k++) begin
            s = 16'hACE1 ^ 16'(P_ID[k]);
            if (s == 16'h0) s = 16'hACE1;
            m_pend[k] = 0; m_loaded[k] = 0; m_valid[k] = 0; m_pkt[k] = '0; m_rd[k] = 2'b00;
            m_sent[k] = 0; m_drop[k] = 0; m_done[k] = 0; m_lfsr[k] = s;
        end
    endtask

    // One clock of the transaction model: request, drop, load and handshake bookkeeping.
    task automatic model_step();
        bit hs, req, ld;
        int d;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < NI; k++) begin
            hs  = m_valid[k] && pkt_ready;
            req = gen_en && (inject_clk_ref == 16'(INJ - 1)) && !m_done[k] &&
                  ((P_Q[k] == 0) || (m_loaded[k] + m_pend[k] < P_Q[k]));
            ld  = (m_pend[k] > 0) && (!m_valid[k] || pkt_ready);
            if ((P_Q[k] != 0) && (m_sent[k] == longint'(P_Q[k]))) m_done[k] = 1;
            if (hs) m_sent[k]++;
            if (ld) begin
                d = exp_dst(k, m_lfsr[k]);
                m_pkt[k]  = {1'b1, clk_counter, 16'(P_ID[k]), 16'(d)};
                m_rd[k]   = exp_route(P_ID[k], d);
                m_lfsr[k] = lfsr_next(m_lfsr[k]);
                m_loaded[k]++;
                m_valid[k] = 1;
            end else if (hs) begin
                m_valid[k] = 0;
            end
            if (req && !ld) begin
                if (m_pend[k] == MAXP) m_drop[k]++;
                else m_pend[k]++;
            end else if (!req && ld) begin
                m_pend[k]--;
            end
        end
    endtask

    task automatic tick();
        clk_counter = clk_counter + 16'd1;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        gen_en = 1'b0;
        pkt_ready = 1'b0;
        inject_clk_ref = 16'd0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (pv[k] !== 1'b0 || pk[k] !== '0 || rd[k] !== 2'b00 || ts[k] !== 64'd0 ||
                td[k] !== 64'd0 || gd[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got valid=%b pkt=%h dir=%b sent=%0d drop=%0d done=%b, expected all zero",
                         k, pv[k], pk[k], rd[k], ts[k], td[k], gd[k]);
            end
        end
        $display("test_reset: outputs sampled during reset");
    endtask

    task automatic test_complement();
        int vcount;
        bit prev_v;
        do_reset();
        gen_en = 1'b1;
        pkt_ready = 1'b1;
        vcount = 0;
        prev_v = 0;
        for (int i = 0; i < 16; i++) begin
            inject_clk_ref = 16'(i % 2);
            tick();
            checks++;
            if (pv[0] !== m_valid[0] || pk[0] !== m_pkt[0] || rd[0] !== m_rd[0] || ts[0] !== 64'(m_sent[0])) begin
                errors++;
                $display("FAIL complement_model cyc%0d: got v=%b pkt=%h dir=%b sent=%0d, expected v=%b pkt=%h dir=%b sent=%0d",
                         i, pv[0], pk[0], rd[0], ts[0], m_valid[0], m_pkt[0], m_rd[0], m_sent[0]);
            end
            if (pv[0]) begin
                vcount++;
                checks++;
                if (pk[0][15:0] !== 16'd5 || rd[0] !== 2'b01 || prev_v) begin
                    errors++;
                    $display("FAIL complement_dst cyc%0d: got dst=%0d dir=%b prev_valid=%b, expected dst=5 dir=01 prev_valid=0",
                             i, pk[0][15:0], rd[0], prev_v);
                end
            end
            prev_v = pv[0];
        end
        checks++;
        if (ts[0] !== 64'd7 || vcount != 7) begin
            errors++;
            $display("FAIL complement_rate: got sent=%0d valid_cycles=%0d, expected 7 and 7", ts[0], vcount);
        end
        $display("test_complement: %0d packets observed", vcount);
    endtask

    task automatic test_backpressure();
        logic [48:0] held;
        bit have;
        int hs;
        do_reset();
        gen_en = 1'b1;
        pkt_ready = 1'b0;
        inject_clk_ref = 16'(INJ - 1);
        have = 0;
        held = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pv[0]) begin
                if (!have) begin
                    held = pk[0];
                    have = 1;
                end
                checks++;
                if (pk[0] !== held) begin
                    errors++;
                    $display("FAIL bp_stable cyc%0d: got pkt=%h, expected held %h", i, pk[0], held);
                end
            end
            checks++;
            if (td[0] !== 64'(m_drop[0]) || pk[0] !== m_pkt[0]) begin
                errors++;
                $display("FAIL bp_model cyc%0d: got drop=%0d pkt=%h, expected drop=%0d pkt=%h",
                         i, td[0], pk[0], m_drop[0], m_pkt[0]);
            end
        end
        checks++;
        if (td[0] !== 64'd15 || pv[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_dropped: got drop=%0d valid=%b, expected drop=15 valid=1", td[0], pv[0]);
        end
        // Drain with generation disabled: the held packet plus four pending.
        gen_en = 1'b0;
        pkt_ready = 1'b1;
        hs = 0;
        for (int i = 0; i < 20; i++) begin
            if (pv[0]) hs++;
            tick();
        end
        checks++;
        if (hs != 5 || ts[0] !== 64'd5 || pv[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got handshakes=%0d sent=%0d valid=%b, expected 5 5 0", hs, ts[0], pv[0]);
        end
        $display("test_backpressure: dropped=%0d drained=%0d", td[0], hs);
    endtask

    task automatic test_quota();
        int hs;
        bit after_done;
        do_reset();
        gen_en = 1'b1;
        pkt_ready = 1'b1;
        hs = 0;
        after_done = 0;
        for (int i = 0; i < 40; i++) begin
            inject_clk_ref = 16'(i % 2);
            if (pv[2]) hs++;
            if (gd[2] && pv[2]) after_done = 1;
            tick();
            checks++;
            if (pv[2] !== m_valid[2] || gd[2] !== m_done[2] || ts[2] !== 64'(m_sent[2])) begin
                errors++;
                $display("FAIL quota_model cyc%0d: got v=%b done=%b sent=%0d, expected v=%b done=%b sent=%0d",
                         i, pv[2], gd[2], ts[2], m_valid[2], m_done[2], m_sent[2]);
            end
        end
        checks++;
        if (hs != 3 || gd[2] !== 1'b1 || ts[2] !== 64'd3 || after_done) begin
            errors++;
            $display("FAIL quota_done: got handshakes=%0d done=%b sent=%0d valid_after_done=%b, expected 3 1 3 0",
                     hs, gd[2], ts[2], after_done);
        end
        $display("test_quota: handshakes=%0d gen_done=%b", hs, gd[2]);
    endtask

    task automatic test_patterns();
        bit seen [NI];
        do_reset();
        gen_en = 1'b1;
        pkt_ready = 1'b1;
        for (int k = 0; k < NI; k++) seen[k] = 0;
        for (int i = 0; i < 10; i++) begin
            inject_clk_ref = 16'(i % 2);
            tick();
            for (int k = 0; k < NI; k++) begin
                if (EXP_DST[k] >= 0 && pv[k]) begin
                    seen[k] = 1;
                    checks++;
                    if (pk[k][15:0] !== 16'(EXP_DST[k]) || rd[k] !== 2'(EXP_RD[k]) || pk[k][31:16] !== 16'(P_ID[k])) begin
                        errors++;
                        $display("FAIL pattern[%0d]: got src=%0d dst=%0d dir=%b, expected src=%0d dst=%0d dir=%0d",
                                 k, pk[k][31:16], pk[k][15:0], rd[k], P_ID[k], EXP_DST[k], EXP_RD[k]);
                    end
                end
            end
        end
        for (int k = 0; k < NI; k++) begin
            if (EXP_DST[k] >= 0) begin
                checks++;
                if (!seen[k]) begin
                    errors++;
                    $display("FAIL pattern_seen[%0d]: got no valid packet, expected at least one", k);
                end
            end
        end
        $display("test_patterns: fixed-destination instances checked");
    endtask

    task automatic test_random();
        logic [15:0] lf;
        int hs, cyc, dst, exp_v;
        do_reset();
        lf = 16'hACE1;
        hs = 0;
        cyc = 0;
        while (hs < 100 && cyc < 3000) begin
            gen_en = ($urandom_range(0, 3) != 0);
            pkt_ready = ($urandom_range(0, 3) != 0);
            inject_clk_ref = 16'($urandom_range(0, 1));
            if (pv[1] && pkt_ready) begin
                dst = int'(pk[1][15:0]);
                exp_v = int'(lf[2:0]);
                if (exp_v == 0) exp_v = 1;
                checks++;
                if (dst != exp_v || dst < 1 || dst > 7) begin
                    errors++;
                    $display("FAIL random_dst pkt%0d: got dst=%0d, expected %0d (range 1..7)", hs, dst, exp_v);
                end
                lf = lfsr_next(lf);
                hs++;
            end
            tick();
            cyc++;
            for (int k = 0; k < NI; k++) begin
                checks++;
                if (pv[k] !== m_valid[k] || pk[k] !== m_pkt[k] || rd[k] !== m_rd[k] ||
                    ts[k] !== 64'(m_sent[k]) || td[k] !== 64'(m_drop[k]) || gd[k] !== m_done[k]) begin
                    errors++;
                    $display("FAIL random_model[%0d] cyc%0d: got v=%b pkt=%h dir=%b sent=%0d drop=%0d done=%b, expected v=%b pkt=%h dir=%b sent=%0d drop=%0d done=%b",
                             k, cyc, pv[k], pk[k], rd[k], ts[k], td[k], gd[k],
                             m_valid[k], m_pkt[k], m_rd[k], m_sent[k], m_drop[k], m_done[k]);
                end
            end
        end
        checks++;
        if (hs != 100) begin
            errors++;
            $display("FAIL random_count: got %0d handshakes in %0d cycles, expected 100", hs, cyc);
        end
        $display("test_random: %0d random-destination packets in %0d cycles", hs, cyc);
    endtask

    task automatic test_reset_midvalid();
        bit found;
        do_reset();
        gen_en = 1'b1;
        pkt_ready = 1'b0;
        inject_clk_ref = 16'(INJ - 1);
        repeat (4) tick();
        checks++;
        if (pv[0] !== 1'b1 || m_pend[0] != 3) begin
            errors++;
            $display("FAIL midvalid_setup: got valid=%b model_pending=%0d, expected 1 and 3", pv[0], m_pend[0]);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (pv[0] !== 1'b0 || pk[0] !== '0 || rd[0] !== 2'b00 || ts[0] !== 64'd0 || td[0] !== 64'd0 || gd[0] !== 1'b0) begin
            errors++;
            $display("FAIL midvalid_async: got v=%b pkt=%h dir=%b sent=%0d drop=%0d done=%b, expected all zero",
                     pv[0], pk[0], rd[0], ts[0], td[0], gd[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pkt_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (pv[0]) begin
                found = 1;
                checks++;
                if (pk[0][47:32] !== clk_counter || pk[0][48] !== 1'b1) begin
                    errors++;
                    $display("FAIL midvalid_timestamp: got ts=%0d flag=%b, expected ts=%0d flag=1",
                             pk[0][47:32], pk[0][48], clk_counter);
                end
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midvalid_restart: got no packet within 10 cycles, expected one");
        end
        $display("test_reset_midvalid: restart packet found=%b", found);
    endtask

    initial begin
        clk_counter = 16'd100;
        inject_clk_ref = 16'd0;
        gen_en = 1'b0;
        pkt_ready = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_complement();
        test_backpressure();
        test_quota();
        test_patterns();
        test_random();
        test_reset_midvalid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
